// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with a req/ack load/store unit, access-fault
// detection and branch/jump resolution, sitting between EX/MEM and MEM/WB.
module mem_stage_lsu #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned TO_W    = 5
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WB_STALL,
   input  logic              MEM_V,
   input  logic [31:0]       MEM_IR,
   input  logic [XLEN-1:0]   MEM_NPC,
   input  logic [XLEN-1:0]   MEM_ALU_RESULT,
   input  logic [XLEN-1:0]   MEM_SR1,
   input  logic [XLEN-1:0]   MEM_SR2,
   input  logic              DMEM_ACK,
   input  logic              DMEM_ERR,
   input  logic [XLEN-1:0]   DMEM_RDATA,
   output logic              DMEM_REQ,
   output logic              DMEM_WE,
   output logic [XLEN-1:0]   DMEM_ADDR,
   output logic [XLEN-1:0]   DMEM_WDATA,
   output logic [XLEN/8-1:0] DMEM_BE,
   output logic              MEM_STALL,
   output logic              WB_V,
   output logic [31:0]       WB_IR,
   output logic [XLEN-1:0]   WB_NPC,
   output logic [XLEN-1:0]   WB_ALU_RESULT,
   output logic [XLEN-1:0]   WB_MEM_RESULT,
   output logic              WB_PC_MUX,
   output logic              WB_LAM,
   output logic              WB_SAM,
   output logic              WB_LAF,
   output logic              WB_SAF,
   output logic              WB_ILL
);
   localparam int unsigned NB    = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(NB);
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t           r_state;
   logic [TO_W-1:0]  r_cnt;
   logic [XLEN-1:0]  r_rdata;
   logic             r_err;

   logic [6:0]       w_opc;
   logic [2:0]       w_f3;
   logic             w_is_load, w_is_store, w_is_mem, w_ill, w_mis, w_go, w_take, w_sx;
   logic [2:0]       w_size_m1;
   logic [OFF_W-1:0] w_off;
   logic [NB-1:0]    w_mask, w_be;
   logic [XLEN-1:0]  w_wdata, w_sh, w_ld;
   logic             w_bubble, w_done;

   assign w_opc      = MEM_IR[6:0];
   assign w_f3       = MEM_IR[14:12];
   assign w_is_load  = (w_opc == OP_LOAD);
   assign w_is_store = (w_opc == OP_STORE);
   assign w_is_mem   = w_is_load | w_is_store;
   assign w_ill      = w_is_mem && (XLEN == 32) &&
                       ((w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_is_load && (w_f3 == 3'b111)));
   assign w_mis      = w_is_mem && !w_ill && ((MEM_ALU_RESULT[2:0] & w_size_m1) != 3'b000);
   assign w_go       = MEM_V && w_is_mem && !w_ill && !w_mis;
   assign w_off      = MEM_ALU_RESULT[OFF_W-1:0];
   assign w_be       = w_mask << w_off;
   assign w_wdata    = MEM_SR2 << {w_off, 3'b000};
   assign w_sh       = r_rdata >> {w_off, 3'b000};
   assign w_sx       = ~w_f3[2];
   assign w_done     = (r_state == S_DONE);
   // WB sees a bubble while an access is still in flight
   assign w_bubble   = (r_state == S_REQ) || ((r_state == S_IDLE) && w_go);

   assign MEM_STALL  = WB_STALL | (w_go & (r_state != S_DONE));

   // size decode, lane extraction and branch resolution
   always_comb begin
      w_size_m1 = 3'b000;
      w_mask    = NB'(8'h01);
      w_ld      = w_sh;
      w_take    = 1'b0;
      case (w_f3[1:0])
         2'b00: begin
            w_size_m1 = 3'b000;
            w_mask    = NB'(8'h01);
            w_ld      = XLEN'($signed({w_sx & w_sh[7], w_sh[7:0]}));
         end
         2'b01: begin
            w_size_m1 = 3'b001;
            w_mask    = NB'(8'h03);
            w_ld      = XLEN'($signed({w_sx & w_sh[15], w_sh[15:0]}));
         end
         2'b10: begin
            w_size_m1 = 3'b011;
            w_mask    = NB'(8'h0F);
            w_ld      = XLEN'($signed({w_sx & w_sh[31], w_sh[31:0]}));
         end
         default: begin
            w_size_m1 = 3'b111;
            w_mask    = NB'(8'hFF);
            w_ld      = w_sh;
         end
      endcase
      if ((w_opc == OP_JAL) || (w_opc == OP_JALR)) begin
         w_take = 1'b1;
      end else if (w_opc == OP_BRANCH) begin
         case (w_f3)
            3'b000:  w_take = (MEM_SR1 == MEM_SR2);
            3'b001:  w_take = (MEM_SR1 != MEM_SR2);
            3'b100:  w_take = ($signed(MEM_SR1) <  $signed(MEM_SR2));
            3'b101:  w_take = ($signed(MEM_SR1) >= $signed(MEM_SR2));
            3'b110:  w_take = (MEM_SR1 <  MEM_SR2);
            3'b111:  w_take = (MEM_SR1 >= MEM_SR2);
            default: w_take = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_rdata       <= '0;
         r_err         <= 1'b0;
         DMEM_REQ      <= 1'b0;
         DMEM_WE       <= 1'b0;
         DMEM_ADDR     <= '0;
         DMEM_WDATA    <= '0;
         DMEM_BE       <= '0;
         WB_V          <= 1'b0;
         WB_IR         <= '0;
         WB_NPC        <= '0;
         WB_ALU_RESULT <= '0;
         WB_MEM_RESULT <= '0;
         WB_PC_MUX     <= 1'b0;
         WB_LAM        <= 1'b0;
         WB_SAM        <= 1'b0;
         WB_LAF        <= 1'b0;
         WB_SAF        <= 1'b0;
         WB_ILL        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_state    <= S_REQ;
                  r_cnt      <= '0;
                  DMEM_REQ   <= 1'b1;
                  DMEM_WE    <= w_is_store;
                  DMEM_ADDR  <= {MEM_ALU_RESULT[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                  DMEM_BE    <= w_be;
                  DMEM_WDATA <= w_is_store ? w_wdata : '0;
               end
            end
            S_REQ: begin
               if (DMEM_ACK) begin
                  DMEM_REQ <= 1'b0;
                  DMEM_WE  <= 1'b0;
                  r_rdata  <= DMEM_RDATA;
                  r_err    <= DMEM_ERR;
                  r_state  <= S_DONE;
               end else if (r_cnt == TO_W'(TIMEOUT - 1)) begin
                  DMEM_REQ <= 1'b0;
                  DMEM_WE  <= 1'b0;
                  r_rdata  <= '0;
                  r_err    <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (!WB_STALL) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         if (!WB_STALL) begin
            WB_V          <= MEM_V & ~w_bubble;
            WB_IR         <= MEM_IR;
            WB_NPC        <= MEM_NPC;
            WB_ALU_RESULT <= MEM_ALU_RESULT;
            WB_MEM_RESULT <= (w_done && w_is_load) ? w_ld : '0;
            WB_PC_MUX     <= MEM_V & ~w_bubble & w_take;
            WB_LAM        <= MEM_V & w_is_load & w_mis;
            WB_SAM        <= MEM_V & w_is_store & w_mis;
            WB_ILL        <= MEM_V & w_ill;
            WB_LAF        <= w_done & w_is_load & r_err;
            WB_SAF        <= w_done & w_is_store & r_err;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu (XLEN=64) with a
// bench-driven memory responder and retirement-order result checking.
module tb_mem_stage_lsu;
   localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BR = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111, OP_ALU = 7'b0110011;
   localparam logic [5:0] F_PCM = 6'b100000, F_LAM = 6'b010000, F_SAM = 6'b001000;
   localparam logic [5:0] F_LAF = 6'b000100, F_SAF = 6'b000010;

   typedef struct {
      logic [31:0] ir;
      logic [63:0] alu;
      logic [63:0] mem;
      logic [5:0]  flags;
   } exp_t;

   logic        CLK = 1'b0, RESET, WB_STALL, MEM_V, DMEM_ACK, DMEM_ERR;
   logic [31:0] MEM_IR, WB_IR;
   logic [63:0] MEM_NPC, MEM_ALU_RESULT, MEM_SR1, MEM_SR2, DMEM_RDATA;
   logic        DMEM_REQ, DMEM_WE, MEM_STALL, WB_V, WB_PC_MUX, WB_LAM, WB_SAM, WB_LAF, WB_SAF, WB_ILL;
   logic [63:0] DMEM_ADDR, DMEM_WDATA, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT;
   logic [7:0]  DMEM_BE;

   exp_t sb[$];
   int   n_checks = 0, n_errors = 0;

   mem_stage_lsu dut (
      .CLK(CLK), .RESET(RESET), .WB_STALL(WB_STALL), .MEM_V(MEM_V), .MEM_IR(MEM_IR),
      .MEM_NPC(MEM_NPC), .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_SR1(MEM_SR1), .MEM_SR2(MEM_SR2),
      .DMEM_ACK(DMEM_ACK), .DMEM_ERR(DMEM_ERR), .DMEM_RDATA(DMEM_RDATA),
      .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
      .DMEM_BE(DMEM_BE), .MEM_STALL(MEM_STALL), .WB_V(WB_V), .WB_IR(WB_IR), .WB_NPC(WB_NPC),
      .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_RESULT(WB_MEM_RESULT), .WB_PC_MUX(WB_PC_MUX),
      .WB_LAM(WB_LAM), .WB_SAM(WB_SAM), .WB_LAF(WB_LAF), .WB_SAF(WB_SAF), .WB_ILL(WB_ILL)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [6:0] opc);
      return {12'h000, 5'd2, f3, 5'd1, opc};
   endfunction

   // reference load: pick bytes lane by lane, then extend by byte fill
   function automatic logic [63:0] exp_load(input logic [63:0] rd, input logic [63:0] a,
                                            input logic [2:0] f3);
      int nb, off;
      logic [63:0] r;
      nb  = 1 << f3[1:0];
      off = int'(a[2:0]);
      r   = '0;
      for (int b = 0; b < 8; b++)
         if (b < nb && off + b < 8) r[8*b +: 8] = rd[8*(off+b) +: 8];
      if (!f3[2] && r[8*nb-1])
         for (int b = 0; b < 8; b++) if (b >= nb) r[8*b +: 8] = 8'hFF;
      return r;
   endfunction

   task automatic compare_wb(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_underflow"}, 64'd1, 64'd0);
         return;
      end
      e = sb.pop_front();
      check({tag, "_wb_v"}, 64'(WB_V), 64'd1);
      check({tag, "_wb_ir"}, 64'(WB_IR), 64'(e.ir));
      check({tag, "_wb_alu"}, WB_ALU_RESULT, e.alu);
      check({tag, "_wb_mem"}, WB_MEM_RESULT, e.mem);
      check({tag, "_wb_flags"}, 64'({WB_PC_MUX, WB_LAM, WB_SAM, WB_LAF, WB_SAF, WB_ILL}), 64'(e.flags));
   endtask

   // issue one instruction at a negedge, answer the memory port, compare at retirement
   task automatic run_op(input string tag, input logic [31:0] ir, input logic [63:0] addr,
                         input logic [63:0] sr1, input logic [63:0] sr2, input int ack_at,
                         input logic [63:0] rdata, input logic err, input logic [63:0] exp_mem,
                         input logic [5:0] exp_flags, output int lat, output int rc,
                         output logic [63:0] ad, output logic [63:0] wd, output logic [7:0] be,
                         output logic we);
      exp_t e;
      int   guard;
      MEM_V = 1'b1; MEM_IR = ir; MEM_ALU_RESULT = addr; MEM_SR1 = sr1; MEM_SR2 = sr2;
      MEM_NPC = addr + 64'h40;
      e.ir = ir; e.alu = addr; e.mem = exp_mem; e.flags = exp_flags;
      sb.push_back(e);
      lat = 1; rc = 0; guard = 0; ad = '0; wd = '0; be = '0; we = 1'b0;
      #1;
      while (MEM_STALL && guard < 100) begin
         if (DMEM_REQ) begin
            if (rc == 0) begin ad = DMEM_ADDR; wd = DMEM_WDATA; be = DMEM_BE; we = DMEM_WE; end
            if (rc == ack_at) begin DMEM_ACK = 1'b1; DMEM_RDATA = rdata; DMEM_ERR = err; end
            rc++;
         end
         @(negedge CLK);
         DMEM_ACK = 1'b0; DMEM_ERR = 1'b0;
         #1;
         lat++; guard++;
      end
      if (guard >= 100) check({tag, "_wait_bound"}, 64'd1, 64'd0);
      @(posedge CLK); #1;
      MEM_V = 1'b0;
      compare_wb(tag);
      @(negedge CLK);
   endtask

   initial begin
      int lat, rc;
      logic [63:0] ad, wd, rd, a;
      logic [7:0]  be;
      logic        we;
      logic [2:0]  f3;
      int          ack;

      RESET = 1'b1; WB_STALL = 1'b0; MEM_V = 1'b0; MEM_IR = '0; MEM_NPC = '0;
      MEM_ALU_RESULT = '0; MEM_SR1 = '0; MEM_SR2 = '0;
      DMEM_ACK = 1'b0; DMEM_ERR = 1'b0; DMEM_RDATA = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("rst_dmem_ctl", 64'({DMEM_REQ, DMEM_WE, DMEM_BE}), 64'd0);
      check("rst_dmem_addr", DMEM_ADDR, 64'd0);
      check("rst_dmem_wdata", DMEM_WDATA, 64'd0);
      check("rst_wb_ctl", 64'({WB_V, WB_PC_MUX, WB_LAM, WB_SAM, WB_LAF, WB_SAF, WB_ILL}), 64'd0);
      check("rst_wb_data", WB_MEM_RESULT | WB_ALU_RESULT | WB_NPC | 64'(WB_IR), 64'd0);
      check("rst_mem_stall", 64'(MEM_STALL), 64'd0);
      @(negedge CLK);

      // LB / LBU, ack in the first REQ cycle
      run_op("lb", mk_ir(3'b000, OP_LOAD), 64'h1003, 64'd0, 64'd0, 0, 64'h00000000_80000000, 1'b0,
             64'hFFFFFFFF_FFFFFF80, 6'd0, lat, rc, ad, wd, be, we);
      check("lb_be", 64'(be), 64'h08);
      check("lb_addr", ad, 64'h1000);
      check("lb_we", 64'(we), 64'd0);
      check("lb_latency", 64'(lat), 64'd3);
      run_op("lbu", mk_ir(3'b100, OP_LOAD), 64'h1003, 64'd0, 64'd0, 0, 64'h00000000_80000000, 1'b0,
             64'h80, 6'd0, lat, rc, ad, wd, be, we);

      // SH into the top lanes
      run_op("sh", mk_ir(3'b001, OP_STORE), 64'h1006, 64'd0, 64'hABCD, 2, 64'd0, 1'b0,
             64'd0, 6'd0, lat, rc, ad, wd, be, we);
      check("sh_be", 64'(be), 64'hC0);
      check("sh_wdata", wd, 64'hABCD0000_00000000);
      check("sh_addr", ad, 64'h1000);
      check("sh_we", 64'(we), 64'd1);
      check("sh_latency", 64'(lat), 64'd5);

      // misaligned LW and SD complete in one cycle without a request
      run_op("lw_mis", mk_ir(3'b010, OP_LOAD), 64'h1002, 64'd0, 64'd0, 0, 64'd0, 1'b0,
             64'd0, F_LAM, lat, rc, ad, wd, be, we);
      check("lw_mis_latency", 64'(lat), 64'd1);
      check("lw_mis_reqs", 64'(rc), 64'd0);
      check("lw_mis_req_after", 64'(DMEM_REQ), 64'd0);
      run_op("sd_mis", mk_ir(3'b011, OP_STORE), 64'h1004, 64'd0, 64'd5, 0, 64'd0, 1'b0,
             64'd0, F_SAM, lat, rc, ad, wd, be, we);
      check("sd_mis_reqs", 64'(rc), 64'd0);

      // store bus error
      run_op("sw_err", mk_ir(3'b010, OP_STORE), 64'h3004, 64'd0, 64'h11223344, 1, 64'd0, 1'b1,
             64'd0, F_SAF, lat, rc, ad, wd, be, we);
      check("sw_err_be", 64'(be), 64'hF0);
      check("sw_err_wdata", wd, 64'h11223344_00000000);

      // load timeout, then a late ACK that must be ignored
      run_op("ld_to", mk_ir(3'b011, OP_LOAD), 64'h2000, 64'd0, 64'd0, -1, 64'd0, 1'b0,
             64'd0, F_LAF, lat, rc, ad, wd, be, we);
      check("ld_to_req_cycles", 64'(rc), 64'd16);
      @(negedge CLK);
      DMEM_ACK = 1'b1; DMEM_RDATA = 64'hDEAD;
      @(negedge CLK);
      DMEM_ACK = 1'b0;
      #1;
      check("late_ack_req", 64'(DMEM_REQ), 64'd0);
      check("late_ack_stall", 64'(MEM_STALL), 64'd0);
      check("late_ack_wb", 64'({WB_V, WB_LAF}), 64'd0);
      @(negedge CLK);

      // branches and jumps
      run_op("blt", mk_ir(3'b100, OP_BR), 64'h100, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 0, 64'd0, 1'b0,
             64'd0, F_PCM, lat, rc, ad, wd, be, we);
      run_op("bltu", mk_ir(3'b110, OP_BR), 64'h104, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 0, 64'd0, 1'b0,
             64'd0, 6'd0, lat, rc, ad, wd, be, we);
      run_op("bge", mk_ir(3'b101, OP_BR), 64'h108, 64'd1, 64'hFFFFFFFF_FFFFFFFF, 0, 64'd0, 1'b0,
             64'd0, F_PCM, lat, rc, ad, wd, be, we);
      run_op("bne_eq", mk_ir(3'b001, OP_BR), 64'h10C, 64'd7, 64'd7, 0, 64'd0, 1'b0,
             64'd0, 6'd0, lat, rc, ad, wd, be, we);
      run_op("b_f3_010", mk_ir(3'b010, OP_BR), 64'h110, 64'd1, 64'd2, 0, 64'd0, 1'b0,
             64'd0, 6'd0, lat, rc, ad, wd, be, we);
      run_op("jal", mk_ir(3'b000, OP_JAL), 64'h114, 64'd0, 64'd0, 0, 64'd0, 1'b0,
             64'd0, F_PCM, lat, rc, ad, wd, be, we);
      run_op("alu", mk_ir(3'b000, OP_ALU), 64'h1234, 64'd0, 64'd0, 0, 64'd0, 1'b0,
             64'd0, 6'd0, lat, rc, ad, wd, be, we);
      MEM_IR = mk_ir(3'b000, OP_JAL);
      @(posedge CLK); #1;
      check("jal_invalid_pcmux", 64'({WB_V, WB_PC_MUX}), 64'd0);
      @(negedge CLK);

      // randomized aligned loads against the byte-lane model
      for (int i = 0; i < 6; i++) begin
         f3  = 3'($urandom_range(0, 6));
         a   = (64'h8000 + 64'($urandom_range(0, 7))) & ~(64'((1 << f3[1:0]) - 1));
         rd  = {32'($urandom), 32'($urandom)};
         ack = $urandom_range(0, 3);
         run_op("rnd_ld", mk_ir(f3, OP_LOAD), a, 64'd0, 64'd0, ack, rd, 1'b0,
                exp_load(rd, a, f3), 6'd0, lat, rc, ad, wd, be, we);
         check("rnd_ld_latency", 64'(lat), 64'(3 + ack));
      end

      // WB_STALL while DONE: result must wait, then latch when the stall drops
      rd = 64'h0123_4567_89AB_CDEF;
      MEM_V = 1'b1; MEM_IR = mk_ir(3'b011, OP_LOAD); MEM_ALU_RESULT = 64'h4008;
      sb.push_back('{ir: mk_ir(3'b011, OP_LOAD), alu: 64'h4008, mem: rd, flags: 6'd0});
      @(negedge CLK); #1;
      check("hold_req_up", 64'(DMEM_REQ), 64'd1);
      DMEM_ACK = 1'b1; DMEM_RDATA = rd;
      @(negedge CLK);
      DMEM_ACK = 1'b0; WB_STALL = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("hold_mem_stall", 64'(MEM_STALL), 64'd1);
         @(posedge CLK); #1;
         check("hold_wb_v", 64'({WB_V, WB_MEM_RESULT != 64'd0}), 64'd0);
         @(negedge CLK); #1;
      end
      WB_STALL = 1'b0;
      #1;
      check("hold_release_stall", 64'(MEM_STALL), 64'd0);
      @(posedge CLK); #1;
      MEM_V = 1'b0;
      compare_wb("hold_ld");
      @(negedge CLK);

      // RESET in the middle of REQ, then a stray ACK in IDLE
      MEM_V = 1'b1; MEM_IR = mk_ir(3'b011, OP_LOAD); MEM_ALU_RESULT = 64'h5000;
      @(negedge CLK);
      @(negedge CLK); #1;
      check("rst_mid_req_up", 64'(DMEM_REQ), 64'd1);
      RESET = 1'b1; MEM_V = 1'b0;
      @(posedge CLK); #1;
      check("rst_mid_req_drop", 64'(DMEM_REQ), 64'd0);
      check("rst_mid_addr", DMEM_ADDR, 64'd0);
      @(negedge CLK);
      RESET = 1'b0; DMEM_ACK = 1'b1;
      @(negedge CLK);
      DMEM_ACK = 1'b0;
      #1;
      check("rst_stray_ack", 64'({DMEM_REQ, MEM_STALL, WB_V, WB_LAF}), 64'd0);

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
